// File: rtl/nbyone_arb_mux.sv
// nbyone_arb_mux: m-to-1 arbitrated mux (fixed select or round-robin) feeding a one-word registered output stage.
module nbyone_arb_mux #(
  parameter int n = 8,
  parameter int m = 4,
  localparam int s = $clog2(m)
) (
  input  logic           in_clk,
  input  logic           in_rst,
  input  logic [m*n-1:0] in_data,
  input  logic [m-1:0]   in_valid,
  output logic [m-1:0]   out_inready,
  input  logic           in_mode,
  input  logic [s-1:0]   in_sel,
  output logic [n-1:0]   out_data,
  output logic           out_valid,
  input  logic           in_outready,
  output logic [s-1:0]   out_chan
);
  logic load, gnt;
  logic [s-1:0] gidx, rr_ptr;
  logic [(1<<s)-1:0] vx;
  logic [n-1:0] ch [m];
  for (genvar g = 0; g < m; g++) begin : g_ch
    assign ch[g] = in_data[g*n +: n];
  end
  assign load = !out_valid || in_outready;
  // vx pads in_valid to a power of two so an out-of-range in_sel reads as not valid
  always_comb begin
    vx = '0;
    vx[m-1:0] = in_valid;
    gnt = 1'b0;
    gidx = '0;
    if (!in_mode) begin
      gnt = vx[in_sel];
      gidx = in_sel;
    end else begin
      for (int k = m - 1; k >= 0; k--) begin
        if (vx[s'((int'(rr_ptr) + k) % m)]) begin
          gnt = 1'b1;
          gidx = s'((int'(rr_ptr) + k) % m);
        end
      end
    end
  end
  assign out_inready = (!in_rst && load && gnt) ? {{(m-1){1'b0}}, 1'b1} << gidx : '0;
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      out_valid <= gnt;
      if (gnt) begin
        out_data <= ch[gidx];
        out_chan <= gidx;
        if (in_mode) rr_ptr <= (int'(gidx) == m - 1) ? '0 : gidx + 1'b1;
      end
    end
  end
endmodule
